// File: rtl/tug_pkg.sv
// Shared types and encodings for the Tug-of-War round/match controller.
package tug_pkg;

  // Width of each per-player score counter.
  localparam int SCORE_W = 3;

  // Round controller states.
  typedef enum logic [1:0] {
    PLAY = 2'b00,
    HOLD = 2'b01,
    DONE = 2'b10
  } tug_state_e;

  // round_win pulse encodings.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b10;
  localparam logic [1:0] WIN_R    = 2'b01;

endpackage

// File: rtl/tug_score_ctr.sv
// Saturating per-player round-win counter with a limit-reached flag.
module tug_score_ctr
  import tug_pkg::*;
#(
  parameter int WIN_SCORE = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  output logic [SCORE_W-1:0] count,
  output logic               hit
);

  localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(WIN_SCORE);

  // Count wins; hold at the limit so the score can never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + SCORE_W'(1);
    end
  end

  assign hit = (count == LIMIT);

endmodule

// File: rtl/tug_round_ctrl.sv
// Tug-of-War round and match controller: arbitrates the two players'
// press pulses, moves the rope light, scores rounds and sequences the
// post-round hold, recenter and end-of-match lockout.
module tug_round_ctrl #(
  parameter int FIELD       = 9,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             l_press,
  input  logic             r_press,
  output logic [FIELD-1:0] pos,
  output logic [2:0]       l_score,
  output logic [2:0]       r_score,
  output logic [1:0]       round_win,
  output logic             match_over
);

  import tug_pkg::*;

  localparam int IW = (FIELD > 1) ? $clog2(FIELD) : 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [IW-1:0] CTR       = IW'((FIELD - 1) / 2);
  localparam logic [IW-1:0] EDGE_L    = IW'(FIELD - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    LAST_WIN  = 3'(WIN_SCORE - 1);

  tug_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rw_q, rw_d;
  logic          l_inc, r_inc;
  logic          l_hit, r_hit;

  // Next-state, rope movement and round-win decisions.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rw_d    = WIN_NONE;
    l_inc   = 1'b0;
    r_inc   = 1'b0;
    case (state_q)
      PLAY: begin
        // Simultaneous presses cancel; only a lone press acts.
        if (l_press && !r_press) begin
          if (idx_q == EDGE_L) begin
            l_inc   = 1'b1;
            rw_d    = WIN_L;
            cnt_d   = HOLD_LOAD;
            state_d = (l_score == LAST_WIN) ? DONE : HOLD;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (r_press && !l_press) begin
          if (idx_q == '0) begin
            r_inc   = 1'b1;
            rw_d    = WIN_R;
            cnt_d   = HOLD_LOAD;
            state_d = (r_score == LAST_WIN) ? DONE : HOLD;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      HOLD: begin
        // The edge light stays lit; the exit cycle itself ignores presses.
        if (cnt_q == '0) begin
          idx_d   = CTR;
          state_d = PLAY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        // Terminal until reset: rope and scores frozen.
      end
      default: begin
        state_d = PLAY;
        idx_d   = CTR;
        cnt_d   = '0;
      end
    endcase
  end

  // Control registers: state, rope index, hold counter, win pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PLAY;
      idx_q   <= CTR;
      cnt_q   <= '0;
      rw_q    <= WIN_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
    end
  end

  tug_score_ctr #(.WIN_SCORE(WIN_SCORE)) u_l_score (
    .clk   (clk),
    .reset (reset),
    .inc   (l_inc),
    .count (l_score),
    .hit   (l_hit)
  );

  tug_score_ctr #(.WIN_SCORE(WIN_SCORE)) u_r_score (
    .clk   (clk),
    .reset (reset),
    .inc   (r_inc),
    .count (r_score),
    .hit   (r_hit)
  );

  // Only the match-winning round brings a score to WIN_SCORE, so either
  // limit flag marks the end of the match.
  assign match_over = l_hit | r_hit;
  assign round_win  = rw_q;
  assign pos        = FIELD'(1) << idx_q;

endmodule

// File: tb/tb_tug_round_ctrl.sv
// Self-checking bench for tug_round_ctrl with a reference model scoreboard.
module tb_tug_round_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       l_press = 1'b0;
  logic       r_press = 1'b0;
  logic [8:0] pos;
  logic [2:0] l_score, r_score;
  logic [1:0] round_win;
  logic       match_over;

  int total = 0;
  int bad   = 0;

  logic [17:0] exp_q[$];
  logic [17:0] obs;

  // Reference model state.
  int m_idx = 4, m_l = 0, m_r = 0, m_st = 0, m_cnt = 0;
  logic [1:0] m_rw = 2'b00;
  logic       m_mo = 1'b0;

  localparam logic [17:0] RESET_VEC = {9'b000010000, 3'd0, 3'd0, 2'b00, 1'b0};

  tug_round_ctrl #(.FIELD(9), .WIN_SCORE(7), .HOLD_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .l_press    (l_press),
    .r_press    (r_press),
    .pos        (pos),
    .l_score    (l_score),
    .r_score    (r_score),
    .round_win  (round_win),
    .match_over (match_over)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge and return the outputs expected after it.
  task automatic model_step(input logic l, input logic r, input logic rst,
                            output logic [17:0] e);
    logic [8:0] p;
    if (rst) begin
      m_idx = 4; m_l = 0; m_r = 0; m_st = 0; m_cnt = 0; m_rw = 2'b00; m_mo = 1'b0;
    end else begin
      m_rw = 2'b00;
      if (m_st == 0) begin
        if (l && !r) begin
          if (m_idx == 8) begin
            m_l++; m_rw = 2'b10; m_cnt = 3;
            if (m_l == 7) begin m_st = 2; m_mo = 1'b1; end else m_st = 1;
          end else m_idx++;
        end else if (r && !l) begin
          if (m_idx == 0) begin
            m_r++; m_rw = 2'b01; m_cnt = 3;
            if (m_r == 7) begin m_st = 2; m_mo = 1'b1; end else m_st = 1;
          end else m_idx--;
        end
      end else if (m_st == 1) begin
        if (m_cnt == 0) begin m_idx = 4; m_st = 0; end else m_cnt--;
      end
    end
    p = 9'd1 << m_idx;
    e = {p, 3'(m_l), 3'(m_r), m_rw, m_mo};
  endtask

  // Drive one cycle of stimulus, record the expectation, sample after the edge.
  task automatic step(input logic l, input logic r, input logic rst);
    logic [17:0] e;
    @(negedge clk);
    l_press = l; r_press = r; reset = rst;
    model_step(l, r, rst, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs = {pos, l_score, r_score, round_win, match_over};
  endtask

  task automatic test_reset();
    logic [17:0] e;
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front(); e = exp_q.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL reset_model: got %h want %h", obs, e); end
    total++;
    if (obs !== RESET_VEC) begin bad++; $display("FAIL reset_values: got %h want %h", obs, RESET_VEC); end
  endtask

  task automatic test_single_press();
    logic [17:0] e;
    step(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL single_press_model: got %h want %h", obs, e); end
    total++;
    if (pos !== 9'b000100000 || l_score !== 3'd0 || r_score !== 3'd0) begin
      bad++; $display("FAIL single_press: pos=%b l=%0d r=%0d want pos=000100000 scores 0", pos, l_score, r_score);
    end
    step(1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
  endtask

  task automatic test_cancel();
    logic [17:0] e;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL cancel_model %0d: got %h want %h", i, obs, e); end
      total++;
      if (pos !== 9'b000010000 || round_win !== 2'b00) begin
        bad++; $display("FAIL cancel %0d: pos=%b rw=%b want 000010000/00", i, pos, round_win);
      end
    end
  endtask

  task automatic test_left_win();
    logic [17:0] e;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL left_win_model %0d: got %h want %h", i, obs, e); end
      if (i == 3) begin
        total++;
        if (pos !== 9'b100000000) begin bad++; $display("FAIL left_edge: pos=%b want 100000000", pos); end
      end
    end
    total++;
    if (l_score !== 3'd1 || round_win !== 2'b10 || pos !== 9'b100000000) begin
      bad++; $display("FAIL left_win: l=%0d rw=%b pos=%b want 1/10/100000000", l_score, round_win, pos);
    end
    // Right presses during the hold must not move the rope.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL hold_model %0d: got %h want %h", i, obs, e); end
      total++;
      if (pos !== ((i < 3) ? 9'b100000000 : 9'b000010000) || round_win !== 2'b00) begin
        bad++; $display("FAIL hold %0d: pos=%b rw=%b", i, pos, round_win);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [17:0] e;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL mid_hold_setup %0d: got %h want %h", i, obs, e); end
    end
    total++;
    if (l_score !== 3'd2) begin bad++; $display("FAIL mid_hold_score: l=%0d want 2", l_score); end
    step(1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (obs !== RESET_VEC) begin bad++; $display("FAIL mid_hold_reset: got %h want %h", obs, RESET_VEC); end
    step(1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    step(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (pos !== 9'b000100000 || obs !== e) begin
      bad++; $display("FAIL after_reset_press: got %h want %h", obs, e);
    end
  endtask

  task automatic test_hold_expire();
    logic [17:0] e;
    step(1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
    end
    step(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (pos !== 9'b000010000 || obs !== e) begin
      bad++; $display("FAIL hold_expire_press: got %h want %h", obs, e);
    end
    step(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (pos !== 9'b000100000 || obs !== e) begin
      bad++; $display("FAIL post_hold_press: got %h want %h", obs, e);
    end
  endtask

  task automatic test_right_match();
    logic [17:0] e;
    step(1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    for (int rnd = 0; rnd < 7; rnd++) begin
      for (int i = 0; i < 5; i++) begin
        step(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL right_round %0d/%0d: got %h want %h", rnd, i, obs, e); end
      end
      if (rnd < 6) begin
        for (int i = 0; i < 4; i++) begin
          step(1'b0, 1'b0, 1'b0);
          e = exp_q.pop_front();
        end
      end
    end
    total++;
    if (r_score !== 3'd7 || match_over !== 1'b1 || pos !== 9'b000000001 || l_score !== 3'd0) begin
      bad++; $display("FAIL match_end: r=%0d mo=%b pos=%b want 7/1/000000001", r_score, match_over, pos);
    end
    for (int i = 0; i < 6; i++) begin
      step(i[0], ~i[0], 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs !== {9'b000000001, 3'd0, 3'd7, 2'b00, 1'b1}) begin
        bad++; $display("FAIL done_frozen %0d: got %h", i, obs);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (obs !== RESET_VEC) begin bad++; $display("FAIL done_reset: got %h want %h", obs, RESET_VEC); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    logic l, r, rst;
    for (int i = 0; i < 400; i++) begin
      l   = ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 79) == 0);
      step(l, r, rst);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL random %0d: got %h want %h", i, obs, e); end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL queue_drain: left=%0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_cancel();
    test_left_win();
    test_reset_mid_hold();
    test_hold_expire();
    test_right_match();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
